// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC ingress path.
// Defaults describe the 2-port, 8-bit reference configuration.
package noc_pkg;

  localparam int FLIT_WIDTH_DEFAULT = 8;
  localparam int PORTS_DEFAULT      = 2;

  // Width of the destination field needed to address `ports` crossbar outputs.
  function automatic int dest_w(input int ports);
    return $clog2(ports);
  endfunction

  typedef logic [FLIT_WIDTH_DEFAULT-1:0] flit_t;

  // Destination field sits in the top bits of the flit header.
  localparam int DEST_LSB_DEFAULT = FLIT_WIDTH_DEFAULT - dest_w(PORTS_DEFAULT);

endpackage

// File: rtl/noc_sync_fifo.sv
// Generic synchronous FIFO with combinational head output.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module noc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             push;
  logic             pop;

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // Storage is intentionally not reset; the pointers alone define validity.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PW'(gi))) mem_reg[gi] <= wr_data;
      end
    end
  endgenerate

  assign rd_data = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/noc_input_buffer.sv
// Per-port crossbar ingress: buffers link flits, presents the head flit with its
// decoded destination until granted, and counts cycles spent waiting for a grant.
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int PORTS    = 2,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int DEST_LSB = WIDTH - dest_w(PORTS),
  parameter int STALL_W  = 8,
  localparam int DW = dest_w(PORTS),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   xb_data,
  output logic [DW-1:0]      xb_dest,
  output logic               xb_dest_en,
  input  logic               xb_ack,
  output logic [CW-1:0]      count,
  output logic [STALL_W-1:0] stall_cnt
);

  logic [WIDTH-1:0]   head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [STALL_W-1:0] stall_cnt_reg;

  // Backpressure depends only on occupancy, so a same-cycle grant never
  // opens space for the link; space appears the cycle after the pop.
  assign in_ready   = !fifo_full;
  assign xb_dest_en = !fifo_empty;
  assign push       = in_valid && in_ready;
  assign pop        = xb_ack && xb_dest_en;

  noc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign xb_data = xb_dest_en ? head : '0;
  assign xb_dest = xb_dest_en ? head[DEST_LSB +: DW] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (xb_dest_en && !xb_ack && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed bench for noc_input_buffer (PORTS=2, WIDTH=8, DEPTH=4, DEST_LSB=7).
module tb_noc_input_buffer;
  import noc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  flit_t      in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] xb_data;
  logic [0:0] xb_dest;
  logic       xb_dest_en;
  logic       xb_ack;
  logic [2:0] count;
  logic [7:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  noc_input_buffer #(
    .PORTS    (2),
    .WIDTH    (8),
    .DEPTH    (4),
    .DEST_LSB (7),
    .STALL_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .xb_data    (xb_data),
    .xb_dest    (xb_dest),
    .xb_dest_en (xb_dest_en),
    .xb_ack     (xb_ack),
    .count      (count),
    .stall_cnt  (stall_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; xb_ack = 1'b0; in_data = '0;
    repeat (2) tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    total++; if (xb_dest_en !== 1'b0) begin bad++; $display("FAIL reset_dest_en: got %0b want 0", xb_dest_en); end
    total++; if (xb_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 0", xb_data); end
    total++; if (stall_cnt !== 8'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_basic;
    in_data = 8'h85; in_valid = 1'b1; xb_ack = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (xb_dest_en !== 1'b1) begin bad++; $display("FAIL basic_dest_en: got %0b want 1", xb_dest_en); end
    total++; if (xb_data !== 8'h85) begin bad++; $display("FAIL basic_data: got %0h want 85", xb_data); end
    total++; if (xb_dest !== 1'b1) begin bad++; $display("FAIL basic_dest: got %0d want 1", xb_dest); end
    tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL basic_count: got %0d want 0", count); end
    total++; if (xb_dest_en !== 1'b0) begin bad++; $display("FAIL basic_drained: got %0b want 0", xb_dest_en); end
    total++; if (stall_cnt !== 8'd0) begin bad++; $display("FAIL basic_stall: got %0d want 0", stall_cnt); end
    xb_ack = 1'b0;
    $display("basic: flit 85 passed through");
  endtask

  task automatic test_fill;
    logic [7:0] flits [4];
    flits[0] = 8'h01; flits[1] = 8'h82; flits[2] = 8'h03; flits[3] = 8'h84;
    xb_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = flits[i]; in_valid = 1'b1;
      tick();
      $display("fill: pushed %02h", flits[i]);
    end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count: got %0d want 4", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready: got %0b want 0", in_ready); end
    in_data = 8'h05;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_fifth_count: got %0d want 4", count); end
    total++; if (xb_data !== 8'h01) begin bad++; $display("FAIL fill_head: got %0h want 01", xb_data); end
    total++; if (xb_dest !== 1'b0) begin bad++; $display("FAIL fill_dest: got %0d want 0", xb_dest); end
    total++; if (stall_cnt !== 8'd4) begin bad++; $display("FAIL fill_stall: got %0d want 4", stall_cnt); end
  endtask

  task automatic test_full_ack;
    logic [7:0] rest [3];
    rest[0] = 8'h82; rest[1] = 8'h03; rest[2] = 8'h84;
    in_data = 8'h55; in_valid = 1'b1; xb_ack = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL fullack_count: got %0d want 3", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fullack_in_ready: got %0b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      total++; if (xb_data !== rest[i]) begin bad++; $display("FAIL fullack_drain%0d: got %0h want %0h", i, xb_data, rest[i]); end
      total++; if (xb_dest !== rest[i][7]) begin bad++; $display("FAIL fullack_dest%0d: got %0d want %0d", i, xb_dest, rest[i][7]); end
      tick();
      $display("full_ack: popped %02h", rest[i]);
    end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL fullack_empty: got %0d want 0", count); end
    xb_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    int mcount = 0;
    int mstall = 4;
    int sent   = 0;
    int rx     = 0;
    int cyc    = 0;
    logic do_push;
    logic do_pop;
    while ((sent < 10 || mcount > 0) && cyc < 60) begin
      in_valid = (sent < 10);
      in_data  = 8'(sent);
      xb_ack   = (cyc % 2 == 1) || (sent >= 10);
      #1;
      total++; if (count !== 3'(mcount)) begin bad++; $display("FAIL b2b_count c%0d: got %0d want %0d", cyc, count, mcount); end
      total++; if (in_ready !== (mcount != 4)) begin bad++; $display("FAIL b2b_in_ready c%0d: got %0b want %0b", cyc, in_ready, mcount != 4); end
      if (mcount != 0) begin
        total++; if (xb_data !== 8'(rx)) begin bad++; $display("FAIL b2b_order c%0d: got %0h want %0h", cyc, xb_data, rx); end
      end
      do_push = in_valid && (mcount != 4);
      do_pop  = xb_ack && (mcount != 0);
      if (mcount != 0 && !xb_ack && mstall < 255) mstall++;
      if (do_pop) begin
        $display("b2b: cycle %0d popped %02h (count %0d)", cyc, rx, mcount);
        rx++;
      end
      if (do_push) sent++;
      mcount = mcount + int'(do_push) - int'(do_pop);
      tick();
      cyc++;
    end
    in_valid = 1'b0; xb_ack = 1'b0;
    total++; if (cyc >= 60) begin bad++; $display("FAIL b2b_timeout: got %0d cycles want <60", cyc); end
    total++; if (rx != 10) begin bad++; $display("FAIL b2b_received: got %0d want 10", rx); end
    total++; if (stall_cnt !== 8'(mstall)) begin bad++; $display("FAIL b2b_stall: got %0d want %0d", stall_cnt, mstall); end
  endtask

  task automatic test_ack_empty;
    xb_ack = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL ackempty_count%0d: got %0d want 0", i, count); end
      total++; if (xb_dest_en !== 1'b0) begin bad++; $display("FAIL ackempty_en%0d: got %0b want 0", i, xb_dest_en); end
    end
    xb_ack = 1'b0; in_data = 8'h7F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (xb_data !== 8'h7F) begin bad++; $display("FAIL ackempty_data: got %0h want 7f", xb_data); end
    total++; if (xb_dest !== 1'b0) begin bad++; $display("FAIL ackempty_dest: got %0d want 0", xb_dest); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL ackempty_push_count: got %0d want 1", count); end
    $display("ack_empty: 7f presented after idle acks");
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h92;
    tick();
    in_valid = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL rstmid_pre_count: got %0d want 3", count); end
    #2 rst = 1'b1;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", count); end
    total++; if (xb_dest_en !== 1'b0) begin bad++; $display("FAIL rstmid_en: got %0b want 0", xb_dest_en); end
    total++; if (xb_data !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %0h want 0", xb_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %0b want 1", in_ready); end
    total++; if (stall_cnt !== 8'd0) begin bad++; $display("FAIL rstmid_stall: got %0d want 0", stall_cnt); end
    #1 rst = 1'b0;
    in_data = 8'h33; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (xb_data !== 8'h33) begin bad++; $display("FAIL rstmid_after_data: got %0h want 33", xb_data); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL rstmid_after_count: got %0d want 1", count); end
    $display("reset_mid: buffer cleared, 33 accepted afterwards");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_ack();
    test_back_to_back();
    test_ack_empty();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_input_buffer.md
Name: noc_input_buffer

Overview:
- Per-port ingress stage sitting directly upstream of the round-robin crossbar; one instance per crossbar input.
- Buffers single-flit packets from the link in a small synchronous FIFO and decodes the destination port from the head flit's header bits.
- Holds the request (data, dest, dest_en) to the crossbar until acked, and exerts backpressure on the link when full.

Parameters:
- PORTS, 2, number of crossbar ports; dest field width DW = $clog2(PORTS).
- WIDTH, 8, flit width in bits.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- DEST_LSB, WIDTH-$clog2(PORTS), bit position of the destination field LSB inside the flit.
- STALL_W, 8, width of the saturating stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_data  in  WIDTH  flit from link.
- in_valid  in  1  flit on in_data is valid.
- in_ready  out  1  buffer can accept; a flit is pushed when in_valid && in_ready.
- xb_data  out  WIDTH  head flit to crossbar data_i.
- xb_dest  out  DW  head destination to crossbar dest.
- xb_dest_en  out  1  head valid / request to crossbar dest_en.
- xb_ack  in  1  crossbar grant for this port, same cycle as the request.
- count  out  $clog2(DEPTH+1)  current occupancy.
- stall_cnt  out  STALL_W  saturating count of cycles with xb_dest_en=1 && xb_ack=0.

Behaviour:
- Storage: DEPTH x WIDTH array, wr_ptr/rd_ptr of $clog2(DEPTH) bits (natural wrap), count register. Array contents are not reset.
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, stall_cnt=0. Therefore in_ready=1, xb_dest_en=0, xb_data=0, xb_dest=0. Reset asserted mid-operation discards all buffered flits immediately.
- in_ready = (count != DEPTH), combinational from count only (never from xb_ack).
- push = in_valid && in_ready; on the edge: mem[wr_ptr] <= in_data, wr_ptr++.
- pop = xb_ack && xb_dest_en; on the edge: rd_ptr++.
- count next: +1 on push only, -1 on pop only, unchanged on both or neither.
- Head outputs are combinational from mem[rd_ptr] and gated by non-empty:
  - xb_dest_en = (count != 0).
  - xb_data = xb_dest_en ? mem[rd_ptr] : 0.
  - xb_dest = xb_dest_en ? mem[rd_ptr][DEST_LSB +: DW] : 0.
- Latency: a flit pushed at edge N is presented at the crossbar in the cycle after N. No fall-through.
- Min residency is 1 cycle. Throughput is 1 flit/cycle when acked every cycle.
- Request stability: while xb_dest_en=1 and no pop, xb_data and xb_dest hold constant. A push to a non-empty FIFO never alters the head.
- Empty: xb_ack while xb_dest_en=0 is ignored (no pop, no pointer change).
- Full: in_valid ignored (in_ready=0), even if a pop occurs the same cycle. Link sees space the following cycle.
- stall_cnt: increments when xb_dest_en && !xb_ack, saturates at 2^STALL_W-1. Cleared only by rst.
- No assertion on out-of-range dest for non-power-of-two PORTS. The crossbar owns that check.

Decomposition:
- noc_pkg holds:
  - localparam-free function dest_w(ports) returning $clog2(ports).
  - typedef flit_t logic [WIDTH-1:0] (parameterised by package default 8).
  - constant DEST_LSB_DEFAULT.
- One sub-module: noc_sync_fifo (generic DEPTH/WIDTH, push/pop, count, head output). noc_input_buffer adds dest decode, output gating and the stall counter.

Test Plan (PORTS=2, WIDTH=8, DEPTH=4, DEST_LSB=7):
- Reset check: rst pulse mid-cycle with 3 flits buffered -> immediately count=0, xb_dest_en=0, xb_data=0, in_ready=1, stall_cnt=0.
- Basic pass: push 0x85 with xb_ack tied 1 -> next cycle xb_dest_en=1, xb_data=0x85, xb_dest=1; following cycle count=0, xb_dest_en=0.
- Fill/backpressure: push 0x01,0x82,0x03,0x84 with xb_ack=0 -> count=4, in_ready=0. A fifth flit 0x05 is not accepted. Head stays 0x01/dest 0. stall_cnt=4 after four stalled cycles.
- Simultaneous push+pop at count=2 -> count stays 2, and the order out is preserved across pointer wrap (send 10 flits 0x00..0x09 with alternating ack, expect the identical sequence out).
- Full + ack same cycle: count=4, in_valid=1, xb_ack=1 -> flit not accepted, count=3. Next cycle in_ready=1.
- Ack while empty: xb_ack=1, count=0 for 5 cycles -> pointers and count unchanged. A subsequent push of 0x7F appears with xb_dest=0.
